booth_dot_accum: RTL and testbench

Downstream consumer of the Booth multiplier's signed product stream. It accumulates LEN consecutive signed products into one dot-product sum, with saturation. It presents each finished sum on a valid/ready output handshake. It sits between the combinational Booth multiplier (4-bit Q/M, 8-bit product) and the result sink, and supplies the sequential control that the multiplier lacks.

---
 rtl/booth_dot_accum_if.sv | 37 +++
 rtl/booth_dot_accum.sv | 119 +++++++++++
 tb/tb_booth_dot_accum.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_dot_accum_if.sv
// booth_dot_accum_if
//   Product-in / dot-product-out handshake bundle for booth_dot_accum.
//   slave  : accumulator side (consumes products, produces sums)
//   master : producer / sink side (testbench or surrounding datapath)
//   Signals:
//     in_valid/in_ready/product : signed product stream, valid/ready
//     clear                     : synchronous abort of partial and pending sums
//     out_valid/out_ready       : completed-sum handshake
//     out_sum/out_sat           : saturated sum and sticky saturation flag
//     count                     : products accepted into the current sum
interface booth_dot_accum_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
);
  localparam int CNT_W = $clog2(LEN + 1);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, product, clear, out_ready,
    output in_ready, out_valid, out_sum, out_sat, count
  );

  modport master (
    output in_valid, product, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, count
  );
endinterface

// File: rtl/booth_dot_accum.sv
// booth_dot_accum
//   Sums LEN consecutive signed products from the Booth multiplier into one
//   saturating dot product and offers it on a valid/ready output.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : booth_dot_accum_if.slave (product stream, clear, result port)
//   Two states: ACCUM takes products, HOLD presents the finished sum and
//   refuses products until the sink takes it.
module booth_dot_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_dot_accum_if.slave      bus
);
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               live_q;

  logic [ACC_W:0]     wide;
  logic               ovf;
  logic [ACC_W-1:0]   acc_nxt;
  logic               accept;
  logic               last;

  // One guard bit: the two top bits of the (ACC_W+1)-bit sum disagree
  // exactly when the true result left the ACC_W-bit signed range.
  assign wide = {acc_q[ACC_W-1], acc_q}
              + {{(ACC_W + 1 - PROD_W){bus.product[PROD_W-1]}}, bus.product};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

  // Clamp toward the side the overflow came from; the guard bit carries
  // the true sign.
  always_comb begin
    acc_nxt = wide[ACC_W-1:0];
    if (ovf) begin
      if (wide[ACC_W]) acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
      else             acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // live_q keeps in_ready low while reset is held and for the cycle in which
  // it is released, so the first accept lands on a clean edge.
  assign bus.in_ready  = live_q && (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_sat   = sat_q;
  assign bus.count     = cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt_q == CNT_W'(LEN - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (bus.clear) begin
      // Abort wins over both the product and the result handshake.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + 1'b1;
            sat_d = sat_q | ovf;
            if (last) begin
              state_d = HOLD;
              sum_d   = acc_nxt;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            // out_sum is left alone; the sink ignores it while out_valid=0.
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      live_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_booth_dot_accum.sv
module tb_booth_dot_accum;
  logic clk;
  logic rst_n;

  booth_dot_accum_if #(.PROD_W(8), .ACC_W(16), .LEN(4)) a16 ();
  booth_dot_accum_if #(.PROD_W(8), .ACC_W(8),  .LEN(4)) a8 ();

  booth_dot_accum #(.PROD_W(8), .ACC_W(16), .LEN(4)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(a16)
  );
  booth_dot_accum #(.PROD_W(8), .ACC_W(8), .LEN(4)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(a8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] p;
    logic [15:0]     sum;
    logic            sat;
  } vec_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        sat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q16[$];
  exp_t q8[$];
  vec_t v16[3];
  vec_t v8[3];

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int s, input bit st);
    vec_t v;
    v.p[0] = 8'(a);
    v.p[1] = 8'(b);
    v.p[2] = 8'(c);
    v.p[3] = 8'(d);
    v.sum  = 16'(s);
    v.sat  = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive one product and wait (bounded) until it is accepted. Called and
  // returns 1 time unit after a rising edge.
  task automatic send(input bit w8, input logic [7:0] p);
    bit rdy;
    int n;
    n = 0;
    if (w8) begin a8.in_valid = 1'b1; a8.product = p; end
    else    begin a16.in_valid = 1'b1; a16.product = p; end
    forever begin
      rdy = w8 ? a8.in_ready : a16.in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL send_timeout in_ready actual=0 expected=1");
        break;
      end
    end
  endtask

  // Scoreboards: a result is consumed when valid && ready && !clear.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a16.out_valid && a16.out_ready && !a16.clear) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb16_unexpected actual=%0h expected=none", a16.out_sum);
      end else begin
        e = q16.pop_front();
        chk("sb16_sum", 32'(a16.out_sum), 32'(e.sum));
        chk("sb16_sat", 32'(a16.out_sat), 32'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a8.out_valid && a8.out_ready && !a8.clear) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb8_unexpected actual=%0h expected=none", a8.out_sum);
      end else begin
        e = q8.pop_front();
        chk("sb8_sum", 32'(a8.out_sum), 32'(e.sum[7:0]));
        chk("sb8_sat", 32'(a8.out_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    v16[0] = mk(21, -21, 21, 30, 51, 1'b0);
    v16[1] = mk(-30, 30, -30, -30, -60, 1'b0);
    v16[2] = mk(127, 127, -128, -128, -2, 1'b0);
    v8[0]  = mk(64, 64, 64, 64, 127, 1'b1);
    v8[1]  = mk(-56, -56, -56, -56, -128, 1'b1);
    v8[2]  = mk(1, 1, 1, 1, 4, 1'b0);

    rst_n = 1'b0;
    a16.in_valid = 1'b0; a16.product = '0; a16.clear = 1'b0; a16.out_ready = 1'b1;
    a8.in_valid  = 1'b0; a8.product  = '0; a8.clear  = 1'b0; a8.out_ready  = 1'b1;
    #1;
    chk("rst_out_valid", 32'(a16.out_valid), 0);
    chk("rst_out_sum",   32'(a16.out_sum), 0);
    chk("rst_out_sat",   32'(a16.out_sat), 0);
    chk("rst_count",     32'(a16.count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven dot products, 16-bit accumulator.
    for (int v = 0; v < 3; v++) begin
      q16.push_back('{sum: v16[v].sum, sat: v16[v].sat});
      for (int k = 0; k < 4; k++) begin
        send(1'b0, v16[v].p[k]);
        chk("count_run", 32'(a16.count), 32'(k + 1));
      end
      chk("lat_out_valid", 32'(a16.out_valid), 1);
      chk("hold_in_ready", 32'(a16.in_ready), 0);
      a16.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("after_hs_in_ready",  32'(a16.in_ready), 1);
      chk("after_hs_out_valid", 32'(a16.out_valid), 0);
      chk("after_hs_count",     32'(a16.count), 0);
    end

    // Table-driven saturation cases, 8-bit accumulator.
    for (int v = 0; v < 3; v++) begin
      q8.push_back('{sum: v8[v].sum, sat: v8[v].sat});
      for (int k = 0; k < 4; k++) send(1'b1, v8[v].p[k]);
      a8.in_valid = 1'b0;
      @(posedge clk); #1;
    end

    // Back-pressure: products offered during HOLD must be ignored.
    a16.out_ready = 1'b0;
    q16.push_back('{sum: 16'd10, sat: 1'b0});
    for (int k = 1; k <= 4; k++) send(1'b0, 8'(k));
    a16.product = 8'd99;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_out_sum",   32'(a16.out_sum), 10);
      chk("bp_in_ready",  32'(a16.in_ready), 0);
      chk("bp_out_valid", 32'(a16.out_valid), 1);
    end
    a16.in_valid  = 1'b0;
    a16.out_ready = 1'b1;
    q16.push_back('{sum: 16'd4, sat: 1'b0});
    for (int k = 0; k < 4; k++) send(1'b0, 8'd1);
    a16.in_valid = 1'b0;
    @(posedge clk); #1;

    // clear mid-sum drops the partial sum and the concurrent product.
    send(1'b0, 8'd7);
    send(1'b0, 8'd8);
    a16.product = 8'd5;
    a16.in_valid = 1'b1;
    a16.clear = 1'b1;
    @(posedge clk); #1;
    a16.clear = 1'b0;
    a16.in_valid = 1'b0;
    chk("clear_count", 32'(a16.count), 0);
    q16.push_back('{sum: 16'd10, sat: 1'b0});
    for (int k = 1; k <= 4; k++) send(1'b0, 8'(k));
    a16.in_valid = 1'b0;
    @(posedge clk); #1;

    // clear in HOLD beats an out_ready in the same cycle.
    a16.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 8'd3);
    a16.in_valid = 1'b0;
    chk("clrhold_pre_valid", 32'(a16.out_valid), 1);
    a16.out_ready = 1'b1;
    a16.clear = 1'b1;
    @(posedge clk); #1;
    a16.clear = 1'b0;
    chk("clrhold_out_valid", 32'(a16.out_valid), 0);
    chk("clrhold_count",     32'(a16.count), 0);
    chk("clrhold_in_ready",  32'(a16.in_ready), 1);

    // Asynchronous reset during the third accept.
    send(1'b0, 8'd1);
    send(1'b0, 8'd1);
    a16.product = 8'd1;
    a16.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst1_count",     32'(a16.count), 0);
    chk("arst1_out_valid", 32'(a16.out_valid), 0);
    chk("arst1_out_sum",   32'(a16.out_sum), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q16.push_back('{sum: 16'd4, sat: 1'b0});
    for (int k = 0; k < 4; k++) send(1'b0, 8'd1);
    a16.in_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset while holding a result.
    a16.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b0, 8'd50);
    a16.in_valid = 1'b0;
    chk("arst2_pre_valid", 32'(a16.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_out_valid", 32'(a16.out_valid), 0);
    chk("arst2_out_sum",   32'(a16.out_sum), 0);
    chk("arst2_out_sat",   32'(a16.out_sat), 0);
    chk("arst2_count",     32'(a16.count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a16.out_ready = 1'b1;
    q16.push_back('{sum: 16'd4, sat: 1'b0});
    for (int k = 0; k < 4; k++) send(1'b0, 8'd1);
    a16.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("sb16_drained", 32'(q16.size()), 0);
    chk("sb8_drained",  32'(q8.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
